// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W    = 12;
  localparam int INSTR_W   = 20;
  localparam int OPCODE_W  = 4;
  localparam int OPCODE_HI = INSTR_W - 1;

  localparam logic [ADDR_W-1:0]   RESET_PC    = 12'h000;
  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  function automatic logic is_halt_op(input logic [INSTR_W-1:0] instr);
    return (instr[OPCODE_HI -: OPCODE_W] == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures memory read data into the IR and hands it to decode.
// Optional PC wrap trap enabled by defining FETCH_WRAP_TRAP_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  Address,
  output logic               ReadEnable,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchTarget,
  input  logic               Resume,
  output logic [INSTR_W-1:0] IR,
  output logic [ADDR_W-1:0]  IRPC,
  output logic               IRValid,
  input  logic               DecodeReady,
  output logic               Halted,
  output logic               Fault
);

  fetch_state_e       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [ADDR_W-1:0]  r_irpc;
  logic               r_ir_valid;
  logic               w_adv;
  logic               w_resume_ok;

`ifdef FETCH_WRAP_TRAP_EN
  logic r_fault;
  assign w_resume_ok = Resume && !r_fault;
  assign Fault       = r_fault;
`else
  assign w_resume_ok = Resume;
  assign Fault       = 1'b0;
`endif

  // rst gates the read strobe because the reset state alone would otherwise advertise a fetch
  assign w_adv      = (r_state == FETCH) && (!r_ir_valid || DecodeReady);
  assign ReadEnable = w_adv && !rst;

  assign Address = r_pc;
  assign IR      = r_ir;
  assign IRPC    = r_irpc;
  assign IRValid = r_ir_valid;
  assign Halted  = (r_state == HALT);

  // PC, IR and state update: redirect beats fetch, fetch beats consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_irpc     <= '0;
      r_ir_valid <= 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      if (BranchTaken) begin
        r_pc       <= BranchTarget;
        r_ir_valid <= 1'b0;
      end else if (w_adv) begin
        r_ir       <= Instruction;
        r_irpc     <= r_pc;
        r_ir_valid <= 1'b1;
        r_pc       <= r_pc + 12'd1;
        if (is_halt_op(Instruction)) begin
          r_state <= HALT;
        end else begin
          r_state <= r_state;
        end
`ifdef FETCH_WRAP_TRAP_EN
        // the last word is still delivered; the trap only stops the wrap-around
        if (r_pc == 12'hFFF) begin
          r_state <= HALT;
          r_fault <= 1'b1;
        end else begin
          r_fault <= r_fault;
        end
`endif
      end else if (r_ir_valid && DecodeReady) begin
        r_ir_valid <= 1'b0;
      end else begin
        r_ir_valid <= r_ir_valid;
      end

      // leaving HALT is independent of a same-cycle redirect, which has already set the PC
      if ((r_state == HALT) && w_resume_ok) begin
        r_state <= FETCH;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a behavioural instruction memory.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic [11:0] Address;
  logic        ReadEnable;
  logic [19:0] Instruction;
  logic        BranchTaken;
  logic [11:0] BranchTarget;
  logic        Resume;
  logic [19:0] IR;
  logic [11:0] IRPC;
  logic        IRValid;
  logic        DecodeReady;
  logic        Halted;
  logic        Fault;

  logic [19:0] mem [0:4095];
  int checks;
  int failures;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .Address(Address), .ReadEnable(ReadEnable),
    .Instruction(Instruction), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Resume(Resume), .IR(IR), .IRPC(IRPC), .IRValid(IRValid),
    .DecodeReady(DecodeReady), .Halted(Halted), .Fault(Fault)
  );

  assign Instruction = mem[Address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 20'h10000 | 20'(i);
    mem[5] = 20'hF0000;

    rst = 1'b1; BranchTaken = 1'b0; BranchTarget = 12'h000; Resume = 1'b0; DecodeReady = 1'b1;
    tick();
    tick();
    check_value("rst_re", 32'(ReadEnable), 32'd0);
    check_value("rst_valid", 32'(IRValid), 32'd0);
    check_value("rst_addr", 32'(Address), 32'h000);
    check_value("rst_halted", 32'(Halted), 32'd0);
    check_value("rst_fault", 32'(Fault), 32'd0);

    // 1: streaming fetch A, B
    rst = 1'b0;
    #1;
    check_value("t1_re", 32'(ReadEnable), 32'd1);
    tick();
    check_value("t1_ir0", 32'(IR), 32'h10000);
    check_value("t1_irpc0", 32'(IRPC), 32'h000);
    check_value("t1_valid0", 32'(IRValid), 32'd1);
    tick();
    check_value("t1_ir1", 32'(IR), 32'h10001);
    check_value("t1_irpc1", 32'(IRPC), 32'h001);

    // 2: back-pressure with B held
    DecodeReady = 1'b0;
    #1;
    check_value("t2_re_stall", 32'(ReadEnable), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_value("t2_ir_hold", 32'(IR), 32'h10001);
      check_value("t2_irpc_hold", 32'(IRPC), 32'h001);
      check_value("t2_pc_hold", 32'(Address), 32'h002);
    end
    DecodeReady = 1'b1;
    #1;
    check_value("t2_re_release", 32'(ReadEnable), 32'd1);
    tick();
    check_value("t2_ir_c", 32'(IR), 32'h10002);
    check_value("t2_irpc_c", 32'(IRPC), 32'h002);
    tick();
    check_value("t2_irpc_d", 32'(IRPC), 32'h003);

    // 3: redirect to 'h100 while IR valid
    BranchTaken = 1'b1; BranchTarget = 12'h100;
    tick();
    BranchTaken = 1'b0;
    check_value("t3_flush", 32'(IRValid), 32'd0);
    check_value("t3_pc", 32'(Address), 32'h100);
    tick();
    check_value("t3_ir", 32'(IR), 32'h10100);
    check_value("t3_irpc", 32'(IRPC), 32'h100);
    check_value("t3_valid", 32'(IRValid), 32'd1);

    // 4: HALT opcode at address 5
    BranchTaken = 1'b1; BranchTarget = 12'h004;
    tick();
    BranchTaken = 1'b0;
    tick();
    check_value("t4_irpc4", 32'(IRPC), 32'h004);
    tick();
    check_value("t4_ir_halt", 32'(IR), 32'hF0000);
    check_value("t4_halted", 32'(Halted), 32'd1);
    check_value("t4_re", 32'(ReadEnable), 32'd0);
    check_value("t4_valid", 32'(IRValid), 32'd1);
    tick();
    check_value("t4_consumed", 32'(IRValid), 32'd0);
    check_value("t4_still_halted", 32'(Halted), 32'd1);
    check_value("t4_pc", 32'(Address), 32'h006);
    Resume = 1'b1;
    tick();
    Resume = 1'b0;
    check_value("t4_resumed", 32'(Halted), 32'd0);
    check_value("t4_re_resume", 32'(ReadEnable), 32'd1);
    tick();
    check_value("t4_irpc6", 32'(IRPC), 32'h006);
    check_value("t4_ir6", 32'(IR), 32'h10006);

    // 5: fetch across the top of the address space
    BranchTaken = 1'b1; BranchTarget = 12'hFFF;
    tick();
    BranchTaken = 1'b0;
    check_value("t5_pc_fff", 32'(Address), 32'hFFF);
    tick();
    check_value("t5_ir_fff", 32'(IR), 32'h10FFF);
    check_value("t5_irpc_fff", 32'(IRPC), 32'hFFF);
    check_value("t5_pc_wrap", 32'(Address), 32'h000);
`ifdef FETCH_WRAP_TRAP_EN
    check_value("t5_trap_halted", 32'(Halted), 32'd1);
    check_value("t5_trap_fault", 32'(Fault), 32'd1);
    tick();
    Resume = 1'b1;
    tick();
    Resume = 1'b0;
    check_value("t5_resume_ignored", 32'(Halted), 32'd1);
    check_value("t5_fault_sticky", 32'(Fault), 32'd1);
`else
    check_value("t5_no_halt", 32'(Halted), 32'd0);
    check_value("t5_no_fault", 32'(Fault), 32'd0);
    tick();
    check_value("t5_irpc_wrap", 32'(IRPC), 32'h000);
    check_value("t5_ir_wrap", 32'(IR), 32'h10000);
`endif

    // 6a: async reset mid-stall
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    DecodeReady = 1'b0;
    tick();
    check_value("t6_stall_valid", 32'(IRValid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_value("t6s_valid", 32'(IRValid), 32'd0);
    check_value("t6s_ir", 32'(IR), 32'h00000);
    check_value("t6s_irpc", 32'(IRPC), 32'h000);
    check_value("t6s_addr", 32'(Address), 32'h000);
    check_value("t6s_re", 32'(ReadEnable), 32'd0);

    // 6b: async reset mid-HALT
    tick();
    rst = 1'b0; DecodeReady = 1'b1;
    BranchTaken = 1'b1; BranchTarget = 12'h005;
    tick();
    BranchTaken = 1'b0;
    tick();
    check_value("t6_halted", 32'(Halted), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_value("t6h_halted", 32'(Halted), 32'd0);
    check_value("t6h_valid", 32'(IRValid), 32'd0);
    check_value("t6h_addr", 32'(Address), 32'h000);
    check_value("t6h_fault", 32'(Fault), 32'd0);
    check_value("t6h_re", 32'(ReadEnable), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
